// File: rtl/elevator_pkg.sv
// Shared types, constants and small helpers for the elevator call panel.
package elevator_pkg;
   localparam int NUM_FLOORS = 8;
   localparam int NUM_SRC    = 3 * NUM_FLOORS;

   typedef logic [2:0] floor_t;
   // Source index is {kind, floor}: up0..up7, dn0..dn7, car0..car7.
   typedef logic [4:0] src_idx_t;

   typedef enum logic [1:0] {
      SRC_UP  = 2'd0,
      SRC_DN  = 2'd1,
      SRC_CAR = 2'd2
   } src_kind_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } issue_state_t;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   localparam logic [NUM_FLOORS-1:0] UP_VALID_MASK = 8'h7F;
   localparam logic [NUM_FLOORS-1:0] DN_VALID_MASK = 8'hFE;

   function automatic src_idx_t src_index(input src_kind_t kind, input floor_t flr);
      return {kind, flr};
   endfunction

   function automatic logic [NUM_SRC-1:0] src_bit(input src_idx_t idx);
      return {{(NUM_SRC-1){1'b0}}, 1'b1} << idx;
   endfunction

   function automatic src_idx_t rr_index(input src_idx_t base, input int offset);
      int sum;
      sum = int'(base) + offset;
      sum = (sum >= NUM_SRC) ? (sum - NUM_SRC) : sum;
      return src_idx_t'(sum);
   endfunction
endpackage

// File: rtl/elevator_call_panel_if.sv
// Request/service link between the call panel (master) and the elevator controller.
interface elevator_call_panel_if;
   import elevator_pkg::*;

   logic   valid_out;
   floor_t req_floor;
   logic   direction;
   floor_t current_floor;
   logic   served_valid;
   floor_t served_floor;
   logic   served_dir;

   modport master (
      output valid_out, req_floor, direction,
      input  current_floor, served_valid, served_floor, served_dir
   );

   modport slave (
      input  valid_out, req_floor, direction,
      output current_floor, served_valid, served_floor, served_dir
   );
endinterface

// File: rtl/elevator_call_panel_button_debounce.sv
// Vector synchroniser plus two-sample debounce filter; emits a one-cycle
// pulse on every 0->1 transition of the filtered level.
module button_debounce #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] rise
);
   logic [WIDTH-1:0] sync1_r;
   logic [WIDTH-1:0] sync2_r;
   logic [WIDTH-1:0] sample_r;
   logic [WIDTH-1:0] level_r;
   logic [WIDTH-1:0] rise_r;
   logic [WIDTH-1:0] level_next_s;

   // Level moves only when the current and previous tick samples agree.
   always_comb begin
      level_next_s = level_r;
      if (tick) begin
         level_next_s = (sync2_r & sample_r) | (level_r & (sync2_r | sample_r));
      end else begin
         level_next_s = level_r;
      end
   end

   // Synchroniser chain, sample history, filtered level and rise pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_r  <= '0;
         sync2_r  <= '0;
         sample_r <= '0;
         level_r  <= '0;
         rise_r   <= '0;
      end else begin
         sync1_r <= raw;
         sync2_r <= sync1_r;
         if (tick) begin
            sample_r <= sync2_r;
         end
         level_r <= level_next_s;
         rise_r  <= level_next_s & ~level_r;
      end
   end

   assign rise = rise_r;
endmodule

// File: rtl/elevator_call_panel.sv
// Elevator call panel: debounces hall/car buttons, latches pending calls and
// issues them one at a time, round-robin, to the elevator controller.
module elevator_call_panel
   import elevator_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int ISSUE_GAP       = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] hall_up_btn,
   input  logic [NUM_FLOORS-1:0] hall_dn_btn,
   input  logic [NUM_FLOORS-1:0] car_btn,
   elevator_call_panel_if.master bus,
   output logic [NUM_FLOORS-1:0] lamp_up,
   output logic [NUM_FLOORS-1:0] lamp_dn,
   output logic [NUM_FLOORS-1:0] lamp_car
);
   localparam int TCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int GW  = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

   logic [TCW-1:0]        tick_cnt_r;
   logic                  tick_s;
   logic [NUM_FLOORS-1:0] rise_up_s, rise_dn_s, rise_car_s;
   logic [NUM_SRC-1:0]    pend_r, issued_r, cand_s;
   logic [NUM_SRC-1:0]    set_s, clr_s, issue_set_s, pend_next_s, issued_next_s;
   issue_state_t          state_r, state_next_s;
   src_idx_t              grant_r, ptr_r, pick_s;
   logic                  found_s;
   logic [GW-1:0]         gap_cnt_r;
   floor_t                grant_floor_s;
   src_kind_t             grant_kind_s, served_kind_s;
   logic                  car_same_s, strobe_ok_s, issue_dir_s;
   logic                  valid_out_r, direction_r;
   floor_t                req_floor_r;

   assign tick_s = (tick_cnt_r == TCW'(DEBOUNCE_CYCLES - 1));

   // Shared debounce sample tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_cnt_r <= '0;
      end else if (tick_s) begin
         tick_cnt_r <= '0;
      end else begin
         tick_cnt_r <= tick_cnt_r + TCW'(1);
      end
   end

   button_debounce #(.WIDTH(NUM_FLOORS)) u_db_up (
      .clk(clk), .reset(reset), .tick(tick_s), .raw(hall_up_btn), .rise(rise_up_s));
   button_debounce #(.WIDTH(NUM_FLOORS)) u_db_dn (
      .clk(clk), .reset(reset), .tick(tick_s), .raw(hall_dn_btn), .rise(rise_dn_s));
   button_debounce #(.WIDTH(NUM_FLOORS)) u_db_car (
      .clk(clk), .reset(reset), .tick(tick_s), .raw(car_btn), .rise(rise_car_s));

   assign cand_s = pend_r & ~issued_r;

   // Round-robin: the smallest offset past the last grant wins.
   always_comb begin
      pick_s = '0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         pick_s = cand_s[rr_index(ptr_r, k)] ? rr_index(ptr_r, k) : pick_s;
      end
      found_s = |cand_s;
   end

   // Decode the registered grant into floor, direction and same-floor case.
   always_comb begin
      grant_floor_s = grant_r[2:0];
      grant_kind_s  = src_kind_t'(grant_r[4:3]);
      car_same_s    = 1'b0;
      issue_dir_s   = DIR_DN;
      case (grant_kind_s)
         SRC_UP:  issue_dir_s = DIR_UP;
         SRC_DN:  issue_dir_s = DIR_DN;
         SRC_CAR: begin
            issue_dir_s = (grant_floor_s > bus.current_floor) ? DIR_UP : DIR_DN;
            car_same_s  = (grant_floor_s == bus.current_floor);
         end
         default: issue_dir_s = DIR_DN;
      endcase
      strobe_ok_s = (state_r == ST_ISSUE) && pend_r[grant_r] && !car_same_s;
   end

   // Pending/issued update; clears win over sets, issued never outlives pending.
   always_comb begin
      served_kind_s = SRC_DN;
      if (bus.served_dir == DIR_UP) begin
         served_kind_s = SRC_UP;
      end else begin
         served_kind_s = SRC_DN;
      end
      set_s = {rise_car_s, rise_dn_s & DN_VALID_MASK, rise_up_s & UP_VALID_MASK};
      clr_s = (bus.served_valid ? (src_bit(src_index(SRC_CAR, bus.served_floor)) |
                                   src_bit(src_index(served_kind_s, bus.served_floor)))
                                : {NUM_SRC{1'b0}})
            | (((state_r == ST_ISSUE) && car_same_s) ? src_bit(grant_r) : {NUM_SRC{1'b0}});
      issue_set_s   = strobe_ok_s ? src_bit(grant_r) : {NUM_SRC{1'b0}};
      pend_next_s   = (pend_r | set_s) & ~clr_s;
      issued_next_s = (issued_r | issue_set_s) & ~clr_s & pend_next_s;
   end

   // Issue FSM next state.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE:  state_next_s = found_s ? ST_ISSUE : ST_IDLE;
         ST_ISSUE: state_next_s = ST_GAP;
         ST_GAP:   state_next_s = (gap_cnt_r == GW'(ISSUE_GAP - 1)) ? ST_IDLE : ST_GAP;
         default:  state_next_s = ST_IDLE;
      endcase
   end

   // FSM state, call bookkeeping and registered request outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         grant_r     <= '0;
         ptr_r       <= '0;
         gap_cnt_r   <= '0;
         pend_r      <= '0;
         issued_r    <= '0;
         valid_out_r <= 1'b0;
         req_floor_r <= '0;
         direction_r <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         pend_r    <= pend_next_s;
         issued_r  <= issued_next_s;
         gap_cnt_r <= (state_r == ST_GAP) ? (gap_cnt_r + GW'(1)) : '0;
         if ((state_r == ST_IDLE) && found_s) begin
            grant_r <= pick_s;
         end
         if (state_r == ST_ISSUE) begin
            ptr_r <= grant_r;
         end
         valid_out_r <= strobe_ok_s;
         if (strobe_ok_s) begin
            req_floor_r <= grant_floor_s;
            direction_r <= issue_dir_s;
         end
      end
   end

   assign bus.valid_out = valid_out_r;
   assign bus.req_floor = req_floor_r;
   assign bus.direction = direction_r;
   assign lamp_up       = pend_r[NUM_FLOORS-1:0];
   assign lamp_dn       = pend_r[2*NUM_FLOORS-1:NUM_FLOORS];
   assign lamp_car      = pend_r[NUM_SRC-1:2*NUM_FLOORS];
endmodule
